// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux select scanner.
package mux_scan_pkg;

    localparam int IDX_W    = 2;
    localparam int NUM_IN   = 4;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } scan_state_t;

    // Select index to {s0,s1}: s0 carries the MSB, s1 the LSB.
    function automatic logic [1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that times the settle wait for each select code.
module scan_settle_timer
    import mux_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_value,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux selects through all codes, samples e per code and publishes a 4-bit word.
// Optional feature: define MUX_SCAN_PARITY_EN to add a registered parity output over word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              e,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              done,
    output logic [NUM_IN-1:0] word
`ifdef MUX_SCAN_PARITY_EN
    , output logic            parity
`endif
);

    localparam bit HAS_SETTLE = (SETTLE > 0);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [1:0]         sel_q;
    logic [1:0]         sel_next;
    logic [NUM_IN-2:0]  shadow;
    logic               settle_zero;

    generate
        if (SETTLE > 0) begin : g_settle
            localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
            logic timer_load;

            // Reload only when entering the wait, so each code gets the full SETTLE cycles.
            assign timer_load = (state != ST_SETTLE) && (next_state == ST_SETTLE);

            scan_settle_timer u_timer (
                .clk        (clk),
                .rst        (rst),
                .load       (timer_load),
                .load_value (SETTLE_LOAD),
                .zero       (settle_zero)
            );
        end else begin : g_no_settle
            assign settle_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        next_state = state;
        idx_next   = idx;
        sel_next   = 2'b00;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_next   = '0;
                    next_state = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (idx == IDX_W'(NUM_IN - 1)) begin
                    next_state = ST_DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    next_state = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // Selects are registered, so they are computed from where the FSM is heading.
        if ((next_state == ST_SETTLE) || (next_state == ST_SAMPLE)) begin
            sel_next = idx_to_sel(idx_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            sel_q  <= 2'b00;
            shadow <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            sel_q <= sel_next;
            if ((state == ST_SAMPLE) && (idx != IDX_W'(NUM_IN - 1))) begin
                shadow[idx] <= e;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word   <= '0;
            parity <= 1'b0;
        end else if ((state == ST_SAMPLE) && (idx == IDX_W'(NUM_IN - 1))) begin
            word   <= {e, shadow};
            parity <= ^{e, shadow};
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if ((state == ST_SAMPLE) && (idx == IDX_W'(NUM_IN - 1))) begin
            word <= {e, shadow};
        end
    end
`endif

    assign s0   = sel_q[1];
    assign s1   = sel_q[0];
    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench: one scanner with SETTLE=0 and one with SETTLE=2, each around a mux model.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start0, start2;
    logic [3:0] in0, in2;
    logic       e0, e2;
    logic       s0_0, s1_0, busy0, done0;
    logic       s0_2, s1_2, busy2, done2;
    logic [3:0] word0, word2;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity0, parity2;
`endif

    int checks = 0;
    int errors = 0;

    // Mux model: in[3:0] = {d,c,b,a}, indexed by {s0,s1}.
    assign e0 = in0[{s0_0, s1_0}];
    assign e2 = in2[{s0_2, s1_2}];

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .start  (start0),
        .e      (e0),
        .s0     (s0_0),
        .s1     (s1_0),
        .busy   (busy0),
        .done   (done0),
        .word   (word0)
`ifdef MUX_SCAN_PARITY_EN
        , .parity (parity0)
`endif
    );

    mux_scan_ctrl #(.SETTLE(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .start  (start2),
        .e      (e2),
        .s0     (s0_2),
        .s1     (s1_2),
        .busy   (busy2),
        .done   (done2),
        .word   (word2)
`ifdef MUX_SCAN_PARITY_EN
        , .parity (parity2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s0_0, s1_0, busy0, done0, word0} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dut0 got %b exp %b", {s0_0, s1_0, busy0, done0, word0}, 8'h00);
        end
        checks++;
        if ({s0_2, s1_2, busy2, done2, word2} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dut2 got %b exp %b", {s0_2, s1_2, busy2, done2, word2}, 8'h00);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if ({parity0, parity2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_parity got %b exp 00", {parity0, parity2});
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({s0_0, s1_0, busy0, done0, word0, s0_2, s1_2, busy2, done2, word2} !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL idle_after_reset cycle %0d got %b exp 0", i,
                         {s0_0, s1_0, busy0, done0, word0, s0_2, s1_2, busy2, done2, word2});
            end
        end
    endtask

    task automatic test_settle0();
        in0    = 4'b0101;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({s0_0, s1_0, busy0, done0} !== {2'(k), 2'b10}) begin
                errors++;
                $display("[TB] FAIL settle0_step %0d got %b exp %b", k, {s0_0, s1_0, busy0, done0}, {2'(k), 2'b10});
            end
            tick();
        end
        checks++;
        if ({s0_0, s1_0, busy0, done0, word0} !== 8'b0001_0101) begin
            errors++;
            $display("[TB] FAIL settle0_done got %b exp %b", {s0_0, s1_0, busy0, done0, word0}, 8'b0001_0101);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (parity0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL settle0_parity got %b exp 0", parity0);
        end
`endif
        tick();
        checks++;
        if ({busy0, done0, word0} !== 6'b00_0101) begin
            errors++;
            $display("[TB] FAIL settle0_after got %b exp %b", {busy0, done0, word0}, 6'b00_0101);
        end
    endtask

    task automatic test_settle2();
        in2    = 4'b1110;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if ({s0_2, s1_2, busy2, done2} !== {2'(k), 2'b10}) begin
                    errors++;
                    $display("[TB] FAIL settle2_step %0d.%0d got %b exp %b", k, j,
                             {s0_2, s1_2, busy2, done2}, {2'(k), 2'b10});
                end
                tick();
            end
        end
        checks++;
        if ({s0_2, s1_2, busy2, done2, word2} !== 8'b0001_1110) begin
            errors++;
            $display("[TB] FAIL settle2_done got %b exp %b", {s0_2, s1_2, busy2, done2, word2}, 8'b0001_1110);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (parity2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL settle2_parity got %b exp 1", parity2);
        end
`endif
        tick();
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL settle2_after got %b exp 00", {busy2, done2});
        end
    endtask

    task automatic test_back_to_back();
        in0    = 4'b0011;
        start0 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({s0_0, s1_0, busy0, done0} !== {2'(k), 2'b10}) begin
                errors++;
                $display("[TB] FAIL b2b_first_step %0d got %b exp %b", k, {s0_0, s1_0, busy0, done0}, {2'(k), 2'b10});
            end
            tick();
        end
        checks++;
        if ({busy0, done0, word0} !== 6'b01_0011) begin
            errors++;
            $display("[TB] FAIL b2b_first_done got %b exp %b", {busy0, done0, word0}, 6'b01_0011);
        end
        in0 = 4'b1100;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({s0_0, s1_0, busy0, done0, word0} !== {2'(k), 2'b10, 4'b0011}) begin
                errors++;
                $display("[TB] FAIL b2b_second_step %0d got %b exp %b", k,
                         {s0_0, s1_0, busy0, done0, word0}, {2'(k), 2'b10, 4'b0011});
            end
            tick();
        end
        checks++;
        if ({busy0, done0, word0} !== 6'b01_1100) begin
            errors++;
            $display("[TB] FAIL b2b_second_done got %b exp %b", {busy0, done0, word0}, 6'b01_1100);
        end
        start0 = 1'b0;
        tick();
        checks++;
        if ({s0_0, s1_0, busy0, done0, word0} !== 8'b0000_1100) begin
            errors++;
            $display("[TB] FAIL b2b_idle got %b exp %b", {s0_0, s1_0, busy0, done0, word0}, 8'b0000_1100);
        end
    endtask

    task automatic test_reset_mid_scan();
        in0    = 4'b1111;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({s0_0, s1_0, busy0, done0, word0} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midscan_async got %b exp 0", {s0_0, s1_0, busy0, done0, word0});
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({s0_0, s1_0, busy0, done0, word0} !== 8'h00) begin
                errors++;
                $display("[TB] FAIL midscan_no_done cycle %0d got %b exp 0", i, {s0_0, s1_0, busy0, done0, word0});
            end
        end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        checks++;
        if ({busy0, done0, word0} !== 6'b01_1111) begin
            errors++;
            $display("[TB] FAIL midscan_rescan got %b exp %b", {busy0, done0, word0}, 6'b01_1111);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        in0    = 4'b0000;
        in2    = 4'b0000;
        $display("[TB] starting mux_scan_ctrl bench");
        test_reset();
        test_settle0();
        test_settle2();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
